// File: rtl/lstm_mvm_pkg.sv
// Shared definitions for the LSTM matrix-vector engine: FSM encoding, Q-format defaults
// and the saturating round-shift used to bring accumulators back to element width.
package lstm_mvm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } mvm_state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAC_BITS  = 8;

   // Widest accumulator / result the helper accepts; callers sign-extend in and slice out.
   localparam int RS_ACC_W = 128;
   localparam int RS_VAL_W = 64;

   typedef struct packed {
      logic                       sat;
      logic signed [RS_VAL_W-1:0] val;
   } rs_res_t;

   function automatic rs_res_t round_shift_sat(input logic signed [RS_ACC_W-1:0] acc,
                                               input int frac,
                                               input int dw);
      logic signed [RS_ACC_W-1:0] rnd;
      logic signed [RS_ACC_W-1:0] shd;
      logic signed [RS_ACC_W-1:0] max_v;
      logic signed [RS_ACC_W-1:0] min_v;
      rs_res_t res;
      res   = '0;
      rnd   = acc;
      if (frac > 0)
         rnd = acc + (RS_ACC_W'(1) <<< (frac - 1));
      shd   = rnd >>> frac;
      max_v = (RS_ACC_W'(1) <<< (dw - 1)) - RS_ACC_W'(1);
      min_v = -(RS_ACC_W'(1) <<< (dw - 1));
      if (shd > max_v) begin
         res.sat = 1'b1;
         res.val = max_v[RS_VAL_W-1:0];
      end else if (shd < min_v) begin
         res.sat = 1'b1;
         res.val = min_v[RS_VAL_W-1:0];
      end else begin
         res.val = shd[RS_VAL_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One output row of the MVM: signed multiply, accumulate, then round/saturate into the output register.
// With MVM_BIAS_EN defined, the first beat seeds the accumulator with the Q-aligned bias.
module mvm_mac_lane
   import lstm_mvm_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACC_WIDTH  = 2*DEF_DATA_WIDTH + 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  beat,
   input  logic                  first,
   input  logic                  close,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] w,
`ifdef MVM_BIAS_EN
   input  logic [DATA_WIDTH-1:0] bias,
`endif
   output logic [DATA_WIDTH-1:0] y,
   output logic                  sat
);

   logic signed [DATA_WIDTH-1:0]   x_s;
   logic signed [DATA_WIDTH-1:0]   w_s;
   logic signed [2*DATA_WIDTH-1:0] prod_p0;
   logic signed [ACC_WIDTH-1:0]    prod_ext_p0;
   logic signed [ACC_WIDTH-1:0]    init_p0;
   logic signed [ACC_WIDTH-1:0]    acc_nxt_p0;
   logic signed [ACC_WIDTH-1:0]    acc_p1;
   rs_res_t                        rs_p0;
   logic                           unused_rs_hi;

   assign x_s         = x;
   assign w_s         = w;
   assign prod_p0     = x_s * w_s;
   assign prod_ext_p0 = ACC_WIDTH'(prod_p0);

`ifdef MVM_BIAS_EN
   logic signed [DATA_WIDTH-1:0] bias_s;
   assign bias_s  = bias;
   assign init_p0 = prod_ext_p0 + (ACC_WIDTH'(bias_s) <<< FRAC_BITS);
`else
   assign init_p0 = prod_ext_p0;
`endif

   // The closing beat's product is folded in before rounding, so the result is ready one cycle later.
   assign acc_nxt_p0   = first ? init_p0 : (acc_p1 + prod_ext_p0);
   assign rs_p0        = round_shift_sat(RS_ACC_W'(acc_nxt_p0), FRAC_BITS, DATA_WIDTH);
   assign unused_rs_hi = ^rs_p0.val[RS_VAL_W-1:DATA_WIDTH];

   // ---- stage p0 -> p1: accumulator and output registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p1 <= '0;
         y      <= '0;
         sat    <= 1'b0;
      end else if (beat) begin
         acc_p1 <= acc_nxt_p0;
         if (close) begin
            y   <= rs_p0.val[DATA_WIDTH-1:0];
            sat <= rs_p0.sat;
         end
      end
   end

endmodule

// File: rtl/mvm_stream_mac_array.sv
// Streaming y = W*x engine: one x element plus weight column per beat, ROWS lanes in parallel.
// Optional bias port enabled by defining MVM_BIAS_EN.
module mvm_stream_mac_array
   import lstm_mvm_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(COLS) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [ROWS*DATA_WIDTH-1:0] in_weight,
   input  logic                       in_last,
`ifdef MVM_BIAS_EN
   input  logic [ROWS*DATA_WIDTH-1:0] bias_in,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ROWS*DATA_WIDTH-1:0] out_data,
   output logic [ROWS-1:0]            out_sat,
   output logic                       busy
);

   localparam int CNT_W = $clog2(COLS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COLS - 1);

   mvm_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             beat;
   logic             close;
   logic             first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (flush || close)
            cnt <= '0;
         else if (beat)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Flush wins over everything and swallows any handshake in the same cycle.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      beat      = 1'b0;
      close     = 1'b0;
      case (state)
         ST_IDLE:  in_ready = 1'b1;
         ST_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
      beat  = in_valid & in_ready & ~flush;
      close = beat & (in_last | (cnt == LAST_CNT));
      case (state)
         ST_IDLE:  if (beat) state_nxt = close ? ST_OUT : ST_ACCUM;
         ST_ACCUM: if (close) state_nxt = ST_OUT;
         ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (flush)
         state_nxt = ST_IDLE;
   end

   assign first = (cnt == '0);

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      mvm_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .beat  (beat),
         .first (first),
         .close (close),
         .x     (in_data),
         .w     (in_weight[r*DATA_WIDTH +: DATA_WIDTH]),
`ifdef MVM_BIAS_EN
         .bias  (bias_in[r*DATA_WIDTH +: DATA_WIDTH]),
`endif
         .y     (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
         .sat   (out_sat[r])
      );
   end

endmodule
